// File: rtl/fb_pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Sequencer states, datapath width and the per-stage control bundle.
package fb_pipe_hazard_ctrl_pkg;

    localparam int FB_32BITS = 32;

    typedef enum logic [1:0] {
        FB_HZ_RUN      = 2'd0,
        FB_HZ_MEM_WAIT = 2'd1,
        FB_HZ_FLUSH    = 2'd2
    } fb_hz_st_e;

    typedef struct packed {
        logic pc_we;
        logic pc_sel;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_en;
    } fb_hz_ctl_t;

    function automatic fb_hz_ctl_t fb_hz_go();
        return '{pc_we: 1'b1, pc_sel: 1'b0,
                 if_id_en: 1'b1, if_id_flush: 1'b0,
                 id_ex_en: 1'b1, id_ex_flush: 1'b0,
                 ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
                 mem_wb_en: 1'b1};
    endfunction

    function automatic fb_hz_ctl_t fb_hz_freeze();
        return '0;
    endfunction

    function automatic fb_hz_ctl_t fb_hz_reset();
        return '{pc_we: 1'b0, pc_sel: 1'b0,
                 if_id_en: 1'b0, if_id_flush: 1'b1,
                 id_ex_en: 1'b0, id_ex_flush: 1'b1,
                 ex_mem_en: 1'b0, ex_mem_flush: 1'b1,
                 mem_wb_en: 1'b0};
    endfunction

endpackage

// File: rtl/fb_pipe_hazard_ctrl_redirect_buf.sv
// Holds a redirect that arrives while the pipe is frozen.
// The oldest captured redirect wins until it is issued.
module fb_hz_redirect_buf
    import fb_pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = FB_32BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture,
    input  logic            issue,
    input  logic            redirect_req,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            redir_act,
    output logic [XLEN-1:0] sel_pc
);

    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (issue) begin
            pend_d = 1'b0;
        end else if (capture && redirect_req && !pend_q) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign redir_act = redirect_req | pend_q;
    assign sel_pc    = pend_q ? pend_pc_q : redirect_pc;

endmodule

// File: rtl/fb_pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core.
// Define FB_HAZARD_PERF_EN to build the stall/flush performance counters.
module fb_pipe_hazard_ctrl
    import fb_pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN      = FB_32BITS,
    parameter int FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_busy,
    input  logic            redirect_req,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            ld_use,
    input  logic            if_busy,
    output logic            pc_we,
    output logic            pc_sel,
    output logic [XLEN-1:0] redir_pc,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            id_ex_en,
    output logic            id_ex_flush,
    output logic            ex_mem_en,
    output logic            ex_mem_flush,
    output logic            mem_wb_en,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

    fb_hz_st_e       st_q, st_d;
    logic [3:0]      cnt_q, cnt_d;
    fb_hz_ctl_t      ctl;
    logic            capture;
    logic            issue;
    logic            redir_act;
    logic [XLEN-1:0] sel_pc;

    fb_hz_redirect_buf #(.XLEN(XLEN)) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (capture),
        .issue        (issue),
        .redirect_req (redirect_req),
        .redirect_pc  (redirect_pc),
        .redir_act    (redir_act),
        .sel_pc       (sel_pc)
    );

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        ctl     = fb_hz_go();
        capture = 1'b0;
        issue   = 1'b0;
        unique case (st_q)
            FB_HZ_RUN, FB_HZ_MEM_WAIT: begin
                st_d = FB_HZ_RUN;
                if (mem_busy) begin
                    ctl     = fb_hz_freeze();
                    capture = 1'b1;
                    st_d    = FB_HZ_MEM_WAIT;
                end else if (redir_act) begin
                    ctl.pc_sel       = 1'b1;
                    ctl.if_id_flush  = 1'b1;
                    ctl.id_ex_flush  = 1'b1;
                    ctl.ex_mem_flush = 1'b1;
                    issue            = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        cnt_d = FLUSH_INIT;
                        st_d  = FB_HZ_FLUSH;
                    end
                end else if (ld_use) begin
                    ctl.pc_we       = 1'b0;
                    ctl.if_id_en    = 1'b0;
                    ctl.id_ex_flush = 1'b1;
                end else if (if_busy) begin
                    ctl.pc_we       = 1'b0;
                    ctl.if_id_flush = 1'b1;
                end
            end
            FB_HZ_FLUSH: begin
                // Younger work is already squashed, so only mem_busy matters
                if (mem_busy) begin
                    ctl = fb_hz_freeze();
                end else begin
                    ctl.if_id_flush = 1'b1;
                    cnt_d           = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) st_d = FB_HZ_RUN;
                end
            end
            default: st_d = FB_HZ_RUN;
        endcase
        if (!rst_n) ctl = fb_hz_reset();
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q  <= FB_HZ_RUN;
            cnt_q <= 4'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && st_q == FB_HZ_FLUSH) assert (!pc_sel);
    end

`ifdef FB_HAZARD_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + {31'b0, ~ctl.pc_we};
        flush_d = flush_q + {31'b0, issue};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 32'b0;
            flush_q <= 32'b0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'b0;
    assign flush_cnt = 32'b0;
`endif

    assign pc_we        = ctl.pc_we;
    assign pc_sel       = ctl.pc_sel;
    assign redir_pc     = rst_n ? sel_pc : '0;
    assign if_id_en     = ctl.if_id_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_en     = ctl.id_ex_en;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign ex_mem_flush = ctl.ex_mem_flush;
    assign mem_wb_en    = ctl.mem_wb_en;

endmodule

// File: tb/tb_fb_pipe_hazard_ctrl.sv
// Bench for fb_pipe_hazard_ctrl: FLUSH_CYC=1 and FLUSH_CYC=3 instances
// checked every cycle against a behavioural model, plus directed literals.
module tb_fb_pipe_hazard_ctrl;

    localparam logic [8:0] C_RST = 9'b000101010;
    localparam logic [8:0] C_GO  = 9'b101010101;
    localparam logic [8:0] C_FRZ = 9'b000000000;
    localparam logic [8:0] C_RED = 9'b111111111;
    localparam logic [8:0] C_LDU = 9'b000011101;
    localparam logic [8:0] C_IFB = 9'b001110101;
    localparam logic [8:0] C_FLS = 9'b101110101;

    typedef struct {
        bit          pend;
        logic [31:0] pend_pc;
        int          fl;
        logic [31:0] stall;
        logic [31:0] flush;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_busy = 1'b0;
    logic        redirect_req = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ld_use = 1'b0;
    logic        if_busy = 1'b0;

    logic        pc_we1, pc_sel1, iie1, iif1, iee1, ief1, eme1, emf1, mwe1;
    logic        pc_we3, pc_sel3, iie3, iif3, iee3, ief3, eme3, emf3, mwe3;
    logic [31:0] rpc1, rpc3, sc1, sc3, fc1, fc3;
    logic [8:0]  ctl1, ctl3;

    int checks = 0;
    int failures = 0;
    mst_t m [2];

    always #5 clk = ~clk;

    fb_pipe_hazard_ctrl #(.XLEN(32), .FLUSH_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc),
        .ld_use(ld_use), .if_busy(if_busy),
        .pc_we(pc_we1), .pc_sel(pc_sel1), .redir_pc(rpc1),
        .if_id_en(iie1), .if_id_flush(iif1),
        .id_ex_en(iee1), .id_ex_flush(ief1),
        .ex_mem_en(eme1), .ex_mem_flush(emf1), .mem_wb_en(mwe1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    fb_pipe_hazard_ctrl #(.XLEN(32), .FLUSH_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc),
        .ld_use(ld_use), .if_busy(if_busy),
        .pc_we(pc_we3), .pc_sel(pc_sel3), .redir_pc(rpc3),
        .if_id_en(iie3), .if_id_flush(iif3),
        .id_ex_en(iee3), .id_ex_flush(ief3),
        .ex_mem_en(eme3), .ex_mem_flush(emf3), .mem_wb_en(mwe3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    assign ctl1 = {pc_we1, pc_sel1, iie1, iif1, iee1, ief1, eme1, emf1, mwe1};
    assign ctl3 = {pc_we3, pc_sel3, iie3, iif3, iee3, ief3, eme3, emf3, mwe3};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Priority model: pending flush cycles, then freeze, redirect, bubble, fetch stall
    function automatic void model_eval(input mst_t s, input int fcyc,
                                       output logic [8:0] c,
                                       output logic [31:0] rp,
                                       output mst_t n);
        n  = s;
        rp = 32'h0;
        if (!rst_n) begin
            c = C_RST;
            n.pend = 0; n.pend_pc = 0; n.fl = 0;
            n.stall = 0; n.flush = 0;
            return;
        end
        if (s.fl > 0) begin
            if (mem_busy) c = C_FRZ;
            else begin c = C_FLS; n.fl = s.fl - 1; end
        end else if (mem_busy) begin
            c = C_FRZ;
            if (redirect_req && !s.pend) begin
                n.pend = 1; n.pend_pc = redirect_pc;
            end
        end else if (redirect_req || s.pend) begin
            c = C_RED;
            rp = s.pend ? s.pend_pc : redirect_pc;
            n.pend = 0;
            n.fl = fcyc - 1;
            n.flush = s.flush + 1;
        end else if (ld_use) c = C_LDU;
        else if (if_busy) c = C_IFB;
        else c = C_GO;
        if (!c[8]) n.stall = s.stall + 1;
    endfunction

    task automatic cmp_dut(input string tag, input mst_t s, input int fcyc,
                           input logic [8:0] ctl, input logic [31:0] rpc,
                           input logic [31:0] sc, input logic [31:0] fc);
        logic [8:0]  c;
        logic [31:0] rp;
        mst_t        n;
        model_eval(s, fcyc, c, rp, n);
        check({tag, "_ctl"}, {23'b0, ctl}, {23'b0, c});
        if (c[7] || !rst_n) check({tag, "_redir_pc"}, rpc, rp);
`ifdef FB_HAZARD_PERF_EN
        check({tag, "_stall_cnt"}, sc, s.stall);
        check({tag, "_flush_cnt"}, fc, s.flush);
`else
        check({tag, "_stall_cnt"}, sc, 32'h0);
        check({tag, "_flush_cnt"}, fc, 32'h0);
`endif
    endtask

    always @(negedge clk) begin
        cmp_dut("m1", m[0], 1, ctl1, rpc1, sc1, fc1);
        cmp_dut("m3", m[1], 3, ctl3, rpc3, sc3, fc3);
    end

    always @(posedge clk) begin
        logic [8:0]  c;
        logic [31:0] rp;
        mst_t        n;
        model_eval(m[0], 1, c, rp, n);
        m[0] = n;
        model_eval(m[1], 3, c, rp, n);
        m[1] = n;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_busy = 0; redirect_req = 0; redirect_pc = 0;
        ld_use = 0; if_busy = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k].pend = 0; m[k].pend_pc = 0; m[k].fl = 0;
            m[k].stall = 0; m[k].flush = 0;
        end

        // reset held for several edges
        repeat (3) begin
            @(negedge clk);
            check("rst_ctl", {23'b0, ctl1}, {23'b0, C_RST});
            check("rst_redir", rpc1, 32'h0);
            next();
        end
        rst_n = 1;
        @(negedge clk);
        check("post_rst_go", {23'b0, ctl1}, {23'b0, C_GO});
        next();

        // single-cycle redirect
        redirect_req = 1; redirect_pc = 32'h40;
        @(negedge clk);
        check("redir_ctl", {23'b0, ctl1}, {23'b0, C_RED});
        check("redir_pc40", rpc1, 32'h40);
        next();
        idle();
        ld_use = 1;
        @(negedge clk);
        check("ld_use_ctl", {23'b0, ctl1}, {23'b0, C_LDU});
        repeat (5) next();
        idle();
        redirect_req = 1; redirect_pc = 32'h80;
        next();
        idle();
        @(negedge clk);
        check("after_redir_go", {23'b0, ctl1}, {23'b0, C_GO});
`ifdef FB_HAZARD_PERF_EN
        check("perf_flush2", fc1, 32'd2);
        check("perf_stall5", sc1, 32'd5);
`else
        check("perf_flush0", fc1, 32'd0);
        check("perf_stall0", sc1, 32'd0);
`endif
        next();

        // redirect arriving during a memory freeze
        mem_busy = 1;
        @(negedge clk);
        check("frz1", {23'b0, ctl1}, {23'b0, C_FRZ});
        next();
        redirect_req = 1; redirect_pc = 32'h100;
        @(negedge clk);
        check("frz2_nosel", {31'b0, pc_sel1}, 32'h0);
        next();
        redirect_req = 0; redirect_pc = 32'h0;
        repeat (2) next();
        mem_busy = 0;
        @(negedge clk);
        check("replay_ctl", {23'b0, ctl1}, {23'b0, C_RED});
        check("replay_pc", rpc1, 32'h100);
        next();
        @(negedge clk);
        check("replay_clear", {23'b0, ctl1}, {23'b0, C_GO});
        repeat (3) next();

        // one-cycle load-use bubble
        ld_use = 1;
        @(negedge clk);
        check("ld_use1", {23'b0, ctl1}, {23'b0, C_LDU});
        next();
        ld_use = 0;
        @(negedge clk);
        check("ld_use_end", {23'b0, ctl1}, {23'b0, C_GO});
        next();

        // FLUSH_CYC=3 with a freeze inside the flush window
        redirect_req = 1; redirect_pc = 32'h200;
        @(negedge clk);
        check("f3_redir", {23'b0, ctl3}, {23'b0, C_RED});
        check("f3_pc", rpc3, 32'h200);
        next();
        redirect_req = 0; mem_busy = 1; ld_use = 1;
        @(negedge clk);
        check("f3_frz_a", {23'b0, ctl3}, {23'b0, C_FRZ});
        next();
        @(negedge clk);
        check("f3_frz_b", {23'b0, ctl3}, {23'b0, C_FRZ});
        next();
        mem_busy = 0; redirect_req = 1; redirect_pc = 32'h300;
        @(negedge clk);
        check("f3_fls_a", {23'b0, ctl3}, {23'b0, C_FLS});
        next();
        @(negedge clk);
        check("f3_fls_b", {23'b0, ctl3}, {23'b0, C_FLS});
        next();
        idle();
        @(negedge clk);
        check("f3_run", {23'b0, ctl3}, {23'b0, C_GO});
        next();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 99) >= 3);
            mem_busy     = ($urandom_range(0, 3) == 0);
            redirect_req = ($urandom_range(0, 4) == 0);
            redirect_pc  = {$urandom_range(0, 65535), 2'b00} & 32'h0003_fffc;
            ld_use       = ($urandom_range(0, 3) == 0);
            if_busy      = ($urandom_range(0, 3) == 0);
            next();
        end
        idle();
        rst_n = 1;
        repeat (4) next();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
